// File: rtl/gray_pkg.sv
// gray_pkg: Gray-code helpers shared by the Gray stream counter and the downstream decode stage.
// Values travel in a fixed-width word. Callers zero-extend their value into it and truncate the
// result. Both functions give the right answer for any width up to GRAY_MAX_W.
package gray_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: prefix XOR running down from the MSB.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_stream_counter.sv
// gray_stream_counter: binary counter that emits each new count as a Gray code on a
// valid/ready stream. It feeds the Gray-to-binary decode stage. Consecutive codes differ in
// exactly one bit.
//
// Optional feature: define GRAY_CNT_DOWN_EN to add the dir port and allow down-counting.
//
// Ports:
//   clk, resetn   clock (rising edge) and asynchronous active-low reset
//   clr           synchronous clear, highest priority
//   load/load_val synchronous load of a binary value; emits its Gray code
//   inc_valid     increment request, accepted when inc_valid && inc_ready
//   inc_ready     combinational: !gray_valid || gray_ready
//   dir           0 = up, 1 = down (only with GRAY_CNT_DOWN_EN)
//   gray_valid    gray holds an unconsumed code
//   gray_ready    downstream consumes gray when gray_valid && gray_ready
//   gray          registered Gray code of the current count
//   tc            registered terminal count (all-ones going up, zero going down)
//
// DATA_WIDTH must be between 2 and gray_pkg::GRAY_MAX_W.
module gray_stream_counter
   import gray_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   input  logic                  inc_valid,
   output logic                  inc_ready,
`ifdef GRAY_CNT_DOWN_EN
   input  logic                  dir,
`endif
   output logic                  gray_valid,
   input  logic                  gray_ready,
   output logic [DATA_WIDTH-1:0] gray,
   output logic                  tc
);

   localparam int unsigned W = DATA_WIDTH;

   logic [W-1:0] count;
   logic [W-1:0] step_val;
   logic         down;
   logic         accept;
   logic         step_tc;
   logic         load_tc;

`ifdef GRAY_CNT_DOWN_EN
   assign down = dir;
`else
   assign down = 1'b0;
`endif

   // The next value for an accepted increment, in the direction sampled this cycle.
   assign step_val = down ? (count - W'(1)) : (count + W'(1));

   // tc is evaluated on the value about to be registered, using the same sampled direction.
   assign step_tc = down ? (step_val == '0) : (step_val == '1);
   assign load_tc = down ? (load_val == '0) : (load_val == '1);

   // A new increment can be taken when the output slot is empty or is being drained.
   assign inc_ready = !gray_valid || gray_ready;
   assign accept    = inc_valid && inc_ready;

   // Priority: clr > load > accepted increment > drain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count      <= '0;
         gray       <= '0;
         gray_valid <= 1'b0;
         tc         <= 1'b0;
      end else if (clr) begin
         count      <= '0;
         gray       <= '0;
         gray_valid <= 1'b0;
         tc         <= 1'b0;
      end else if (load) begin
         count      <= load_val;
         gray       <= W'(bin2gray(gray_word_t'(load_val)));
         gray_valid <= 1'b1;
         tc         <= load_tc;
      end else if (accept) begin
         count      <= step_val;
         gray       <= W'(bin2gray(gray_word_t'(step_val)));
         gray_valid <= 1'b1;
         tc         <= step_tc;
      end else if (gray_valid && gray_ready) begin
         gray_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_stream_counter.sv
// Directed bench for gray_stream_counter at W=4. It also covers the down-count build when
// GRAY_CNT_DOWN_EN is defined.
module tb_gray_stream_counter;
   import gray_pkg::*;

   localparam int unsigned W = 4;

   logic         clk;
   logic         resetn;
   logic         clr;
   logic         load;
   logic [W-1:0] load_val;
   logic         inc_valid;
   logic         inc_ready;
   logic         gray_valid;
   logic         gray_ready;
   logic [W-1:0] gray;
   logic         tc;
   logic         dn;

   int total = 0;
   int bad   = 0;

   gray_stream_counter #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (clr),
      .load       (load),
      .load_val   (load_val),
      .inc_valid  (inc_valid),
      .inc_ready  (inc_ready),
`ifdef GRAY_CNT_DOWN_EN
      .dir        (dn),
`endif
      .gray_valid (gray_valid),
      .gray_ready (gray_ready),
      .gray       (gray),
      .tc         (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Gray codes of counts 1..15, then 0, written out by hand.
      logic [3:0] up_codes [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      logic [3:0] prev;
      logic [3:0] model;

      resetn     = 1'b0;
      clr        = 1'b0;
      load       = 1'b0;
      load_val   = '0;
      inc_valid  = 1'b0;
      gray_ready = 1'b0;
      dn         = 1'b0;
      step();
      step();
      resetn = 1'b1;
      step();

      // 1. Reset state
      chk("rst_gray",  32'(gray), 32'h0);
      chk("rst_valid", 32'(gray_valid), 32'h0);
      chk("rst_tc",    32'(tc), 32'h0);
      chk("rst_ready", 32'(inc_ready), 32'h1);

      // 2. Full-throughput count through a wrap
      inc_valid  = 1'b1;
      gray_ready = 1'b1;
      prev       = 4'h0;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("run_gray_%0d", k), 32'(gray), 32'(up_codes[k-1]));
         chk($sformatf("run_valid_%0d", k), 32'(gray_valid), 32'h1);
         chk($sformatf("run_tc_%0d", k), 32'(tc), (k == 15) ? 32'h1 : 32'h0);
         chk($sformatf("run_onebit_%0d", k), 32'($countones(gray ^ prev)), 32'h1);
         prev = gray;
      end
      inc_valid = 1'b0;
      step();
      chk("drain_valid", 32'(gray_valid), 32'h0);
      chk("drain_gray",  32'(gray), 32'h0);

      // 3. Backpressure after the first code
      inc_valid = 1'b1;
      step();
      chk("bp_first", 32'(gray), 32'h1);
      gray_ready = 1'b0;
      #1;
      chk("bp_ready0", 32'(inc_ready), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("bp_hold_%0d", k), 32'(gray), 32'h1);
         chk($sformatf("bp_valid_%0d", k), 32'(gray_valid), 32'h1);
         chk($sformatf("bp_ready_%0d", k), 32'(inc_ready), 32'h0);
      end
      gray_ready = 1'b1;
      step();
      chk("bp_next", 32'(gray), 32'h3);
      inc_valid = 1'b0;
      step();
      chk("bp_drain_valid", 32'(gray_valid), 32'h0);
      chk("bp_drain_gray",  32'(gray), 32'h3);

      // 4. Load, then increment from the loaded value
      load     = 1'b1;
      load_val = 4'b1011;
      step();
      chk("load_gray",  32'(gray), 32'hE);
      chk("load_valid", 32'(gray_valid), 32'h1);
      chk("load_tc",    32'(tc), 32'h0);
      load      = 1'b0;
      inc_valid = 1'b1;
      step();
      chk("load_inc_gray", 32'(gray), 32'hA);
      // A load beats a same-cycle increment. Loading 15 raises tc.
      load     = 1'b1;
      load_val = 4'b1111;
      step();
      chk("load15_gray", 32'(gray), 32'h8);
      chk("load15_tc",   32'(tc), 32'h1);

      // 5. clr beats load and inc in the same cycle
      clr = 1'b1;
      step();
      chk("clr_gray",  32'(gray), 32'h0);
      chk("clr_valid", 32'(gray_valid), 32'h0);
      chk("clr_tc",    32'(tc), 32'h0);
      clr  = 1'b0;
      load = 1'b0;
      step();
      chk("clr_then_inc", 32'(gray), 32'h1);
      step();
      step();
      chk("pre_rst_gray", 32'(gray), 32'h2);
      // Assert reset mid-cycle; the outputs must clear without waiting for a clock edge.
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_gray",  32'(gray), 32'h0);
      chk("arst_valid", 32'(gray_valid), 32'h0);
      chk("arst_tc",    32'(tc), 32'h0);
      inc_valid = 1'b0;
      step();
      resetn = 1'b1;
      step();
      chk("arst_ready", 32'(inc_ready), 32'h1);

      // 6. Decode the stream and compare it with a running model count
`ifdef GRAY_CNT_DOWN_EN
      dn = 1'b1;
`endif
      inc_valid = 1'b1;
      step();
      if (dn) begin
         chk("dn_first_gray", 32'(gray), 32'h8);
         chk("dn_first_tc",   32'(tc), 32'h0);
      end else begin
         chk("up_first_gray", 32'(gray), 32'h1);
      end
      model = dn ? 4'hF : 4'h1;
      chk("dec_0", gray2bin(gray_word_t'(gray)), 32'(model));
      for (int k = 1; k <= 18; k++) begin
         step();
         model = dn ? (model - 4'h1) : (model + 4'h1);
         chk($sformatf("dec_%0d", k), gray2bin(gray_word_t'(gray)), 32'(model));
         chk($sformatf("dec_tc_%0d", k), 32'(tc),
             (dn ? (model == 4'h0) : (model == 4'hF)) ? 32'h1 : 32'h0);
      end
      inc_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
